uart_rx_deser: RTL and testbench

- UART receive front end: deserialises the asynchronous `uart_rx` line into bytes, 8N1 by default.
- Presents each byte on a valid/ready handshake to the downstream echo/TX path of the loopback top.
- Sits directly between the `uart_rx` pin and the byte consumer (TX serialiser).
- Flags framing errors and overruns as single-cycle pulses.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_deser_if.sv | 39 +++
 rtl/uart_sync2.sv | 33 +++
 rtl/uart_rx_deser.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive front end and its neighbours
// (TX serialiser, loopback top, benches).
//   uart_state_e : receiver FSM states
//   baud_div()   : clock cycles per bit (integer division, truncating)
//   BIT_NS       : bit period in ns at the default line rate, for benches
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 115200;
    localparam int BIT_NS        = 1_000_000_000 / DEF_BAUD_RATE;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_if
// Byte-side handshake bundle between the UART receiver and its consumer.
//   rx_data       : received byte, stable while rx_valid=1
//   rx_valid      : byte available
//   rx_ready      : consumer accepts (transfer on rx_valid & rx_ready)
//   rx_frame_err  : 1-cycle pulse, stop bit sampled low
//   rx_overrun    : 1-cycle pulse, byte dropped because rx_valid was held
//   rx_parity_err : 1-cycle pulse, parity mismatch (0 when parity is absent)
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_deser_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output rx_frame_err,
        output rx_overrun,
        output rx_parity_err
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  rx_frame_err,
        input  rx_overrun,
        input  rx_parity_err
    );
endinterface

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for an asynchronous single-bit input. Both flops take
// RST_VAL on synchronous reset so an idle-high line does not look like a start
// bit while reset is released.
//   clk  : destination clock
//   rst  : synchronous active-high reset
//   d_i  : asynchronous input
//   q_o  : synchronised output
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// UART receive front end. Deserialises the uart_rx line (8N1 by default, LSB
// first) and offers each byte on a valid/ready handshake. Framing errors and
// overruns are reported as single-cycle pulses.
//
// Optional build macro: UART_RX_PARITY_EN
//   defined   : one even-parity bit follows the data bits; a mismatch pulses
//               rx_parity_err alongside the stop-bit decision, byte still kept
//   undefined : no parity bit, rx_parity_err is constant 0
//
// Ports:
//   sys_clk : system clock, rising edge
//   sys_rst : synchronous active-high reset
//   uart_rx : asynchronous serial input, idle high
//   rx_if   : byte handshake bundle (master side), see uart_rx_deser_if
// -----------------------------------------------------------------------------
module uart_rx_deser #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            uart_rx,
    uart_rx_deser_if.master rx_if
);
    import uart_pkg::*;

    localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rxs;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 done_d;
    logic                 ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d_i (uart_rx),
        .q_o (rxs)
    );

    // Next-state logic. Every sample point is where the bit counter hits 0;
    // the start bit is checked at its midpoint, so later samples land mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        // Line back high at mid-start: a glitch, not a frame.
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = rxs;
                    cnt_d   = CNT_FULL;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
`ifdef UART_RX_PARITY_EN
                    // Even parity: data bits plus parity bit hold an even
                    // number of ones.
                    perr_d = (par_q != ^shift_q);
`endif
                    if (rxs) begin
                        // Return to IDLE at mid-stop so a following start
                        // edge with no idle time is still caught.
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                // A low line after a bad stop bit (break) must not be taken
                // as a new start bit.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
            // A completed byte wins over a pending one only if the pending
            // one is being accepted this cycle; otherwise it is dropped.
            ovr_q <= done_d && valid_q && !rx_if.rx_ready;
            if (done_d && (!valid_q || rx_if.rx_ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        shift_q <= shift_d;
    end

    assign rx_if.rx_data      = data_q;
    assign rx_if.rx_valid     = valid_q;
    assign rx_if.rx_frame_err = ferr_q;
    assign rx_if.rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.rx_parity_err = perr_q;
`else
    assign rx_if.rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
// Bench for uart_rx_deser. A fast-baud instance (50 bit-clocks per bit) takes
// most of the traffic; a default-parameter instance receives one frame at
// 8680 ns/bit. Frames are built from their bit-level definition and the
// received bytes are compared with queues of what was sent.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser;
    import uart_pkg::*;

    localparam int CLK_FREQ    = 50_000_000;
    localparam int FAST_BAUD   = 1_000_000;
    localparam int FAST_BIT_NS = 1_000_000_000 / FAST_BAUD;
    localparam int DEF_BIT_NS  = BIT_NS;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_rx_def = 1'b1;

    always #10 sys_clk = ~sys_clk;

    uart_rx_deser_if #(.DATA_BITS(8)) fast_if ();
    uart_rx_deser_if #(.DATA_BITS(8)) def_if ();

    uart_rx_deser #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (FAST_BAUD),
        .DATA_BITS (8)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .uart_rx (uart_rx),
        .rx_if   (fast_if)
    );

    uart_rx_deser dut_def (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .uart_rx (uart_rx_def),
        .rx_if   (def_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observed activity of the fast instance.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int   n_rise, n_ferr, n_ovr, n_perr;
    time  last_rise;
    logic prev_valid = 1'b0;

    // Observed activity of the default instance.
    int         def_rises = 0;
    time        def_rise_t;
    logic [7:0] def_data;
    logic       def_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (fast_if.rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            n_rise++;
            last_rise = $time;
        end
        prev_valid = fast_if.rx_valid;
        if (fast_if.rx_valid === 1'b1 && fast_if.rx_ready === 1'b1) got_q.push_back(fast_if.rx_data);
        if (fast_if.rx_frame_err === 1'b1) n_ferr++;
        if (fast_if.rx_overrun === 1'b1) n_ovr++;
        if (fast_if.rx_parity_err === 1'b1) n_perr++;
        if (def_if.rx_valid === 1'b1 && def_prev !== 1'b1) begin
            def_rises++;
            def_rise_t = $time;
            def_data   = def_if.rx_data;
        end
        def_prev = def_if.rx_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        n_rise = 0;
        n_ferr = 0;
        n_ovr  = 0;
        n_perr = 0;
    endtask

    // Start bit, 8 data bits LSB first, optional even parity, stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        #(FAST_BIT_NS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(FAST_BIT_NS);
        end
        if (PAR_BITS != 0) begin
            uart_rx = ^b;
            #(FAST_BIT_NS);
        end
        uart_rx = stop_bit;
        #(FAST_BIT_NS);
        uart_rx = 1'b1;
    endtask

    task automatic send_def_frame(input logic [7:0] b);
        uart_rx_def = 1'b0;
        #(DEF_BIT_NS);
        for (int i = 0; i < 8; i++) begin
            uart_rx_def = b[i];
            #(DEF_BIT_NS);
        end
        if (PAR_BITS != 0) begin
            uart_rx_def = ^b;
            #(DEF_BIT_NS);
        end
        uart_rx_def = 1'b1;
        #(DEF_BIT_NS);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        uart_rx = 1'b1;
        uart_rx_def = 1'b1;
        cycles(5);
        n_checks++;
        if (fast_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", fast_if.rx_valid); end
        n_checks++;
        if (fast_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h expected 00", fast_if.rx_data); end
        n_checks++;
        if (fast_if.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", fast_if.rx_frame_err); end
        n_checks++;
        if (fast_if.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", fast_if.rx_overrun); end
        n_checks++;
        if (fast_if.rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", fast_if.rx_parity_err); end
        n_checks++;
        if (def_if.rx_valid !== 1'b0 || def_if.rx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_def: got valid=%b data=%02h expected 0/00", def_if.rx_valid, def_if.rx_data);
        end
        sys_rst = 1'b0;
        clear_obs();
        #20000;
        n_checks++;
        if (n_rise !== 0) begin n_fail++; $display("FAIL idle_no_valid: got %0d rises expected 0", n_rise); end
    endtask

    task automatic test_single();
        time t0;
        time lo;
        time hi;
        // Default-rate instance: 'A' at 8680 ns/bit.
        @(posedge sys_clk); #1;
        t0 = $time;
        send_def_frame(8'h41);
        cycles(2);
        lo = t0 + (2 * (9 + PAR_BITS) + 1) * DEF_BIT_NS / 2;
        hi = lo + DEF_BIT_NS;
        n_checks++;
        if (def_rises !== 1 || def_data !== 8'h41) begin
            n_fail++; $display("FAIL def_single: got %0d bytes data=%02h expected 1 byte 41", def_rises, def_data);
        end
        n_checks++;
        if (!(def_rise_t > lo && def_rise_t < hi)) begin
            n_fail++; $display("FAIL def_latency: got rise at %0t expected between %0t and %0t", def_rise_t, lo, hi);
        end
        // Fast instance: same byte.
        clear_obs();
        t0 = $time;
        send_frame(8'h41, 1'b1);
        cycles(2);
        lo = t0 + (2 * (9 + PAR_BITS) + 1) * FAST_BIT_NS / 2;
        hi = lo + FAST_BIT_NS;
        n_checks++;
        if (got_q.size() !== 1 || n_rise !== 1) begin
            n_fail++; $display("FAIL single_count: got %0d bytes %0d rises expected 1/1", got_q.size(), n_rise);
        end else if (got_q[0] !== 8'h41) begin
            n_fail++; $display("FAIL single_data: got %02h expected 41", got_q[0]);
        end
        n_checks++;
        if (!(last_rise > lo && last_rise < hi)) begin
            n_fail++; $display("FAIL single_latency: got rise at %0t expected between %0t and %0t", last_rise, lo, hi);
        end
    endtask

    task automatic test_back_to_back();
        string msg = "Hello, world!";
        logic [7:0] g;
        clear_obs();
        for (int i = 0; i < msg.len(); i++) begin
            exp_q.push_back(msg[i]);
            send_frame(msg[i], 1'b1);
        end
        cycles(2);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL hello_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_checks++;
            if (g !== exp_q[i]) begin n_fail++; $display("FAIL hello_byte[%0d]: got %02h expected %02h", i, g, exp_q[i]); end
        end
        n_checks++;
        if (n_ferr !== 0 || n_ovr !== 0 || n_perr !== 0) begin
            n_fail++; $display("FAIL hello_errors: got ferr=%0d ovr=%0d perr=%0d expected 0/0/0", n_ferr, n_ovr, n_perr);
        end
    endtask

    task automatic test_overrun();
        clear_obs();
        fast_if.rx_ready = 1'b0;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        cycles(2);
        n_checks++;
        if (fast_if.rx_valid !== 1'b1 || fast_if.rx_data !== 8'h55) begin
            n_fail++; $display("FAIL ovr_hold: got valid=%b data=%02h expected 1/55", fast_if.rx_valid, fast_if.rx_data);
        end
        n_checks++;
        if (n_ovr !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d pulses expected 1", n_ovr); end
        n_checks++;
        if (got_q.size() !== 0 || n_rise !== 1) begin
            n_fail++; $display("FAIL ovr_no_transfer: got %0d transfers %0d rises expected 0/1", got_q.size(), n_rise);
        end
        fast_if.rx_ready = 1'b1;
        cycles(3);
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL ovr_accept_count: got %0d expected 1", got_q.size());
        end else if (got_q[0] !== 8'h55) begin
            n_fail++; $display("FAIL ovr_accept_data: got %02h expected 55", got_q[0]);
        end
        n_checks++;
        if (fast_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b expected 0", fast_if.rx_valid); end
    endtask

    task automatic test_frame_err();
        clear_obs();
        send_frame(8'h3C, 1'b0);
        uart_rx = 1'b0;
        #(2 * FAST_BIT_NS);
        uart_rx = 1'b1;
        #(FAST_BIT_NS);
        send_frame(8'h7E, 1'b1);
        cycles(2);
        n_checks++;
        if (n_ferr !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulses expected 1", n_ferr); end
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL ferr_count: got %0d bytes expected 1", got_q.size());
        end else if (got_q[0] !== 8'h7E) begin
            n_fail++; $display("FAIL ferr_next_data: got %02h expected 7e", got_q[0]);
        end
    endtask

    task automatic test_glitch_and_reset();
        logic [7:0] b = 8'h99;
        clear_obs();
        // Low pulse of 10 clocks, well under half a bit.
        uart_rx = 1'b0;
        #200;
        uart_rx = 1'b1;
        #(3 * FAST_BIT_NS);
        n_checks++;
        if (n_rise !== 0 || n_ferr !== 0) begin
            n_fail++; $display("FAIL glitch: got %0d rises %0d ferr expected 0/0", n_rise, n_ferr);
        end
        // Start 0x99, reset during its data bits, line released high.
        uart_rx = 1'b0;
        #(FAST_BIT_NS);
        for (int i = 0; i < 4; i++) begin
            uart_rx = b[i];
            #(FAST_BIT_NS);
        end
        sys_rst = 1'b1;
        uart_rx = 1'b1;
        cycles(5);
        sys_rst = 1'b0;
        #(2 * FAST_BIT_NS);
        n_checks++;
        if (n_rise !== 0 || fast_if.rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_abandon: got %0d rises valid=%b expected 0/0", n_rise, fast_if.rx_valid);
        end
        send_frame(8'h12, 1'b1);
        cycles(2);
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL post_reset_count: got %0d expected 1", got_q.size());
        end else if (got_q[0] !== 8'h12) begin
            n_fail++; $display("FAIL post_reset_data: got %02h expected 12", got_q[0]);
        end
        n_checks++;
        if (n_ferr !== 0 || n_ovr !== 0) begin
            n_fail++; $display("FAIL post_reset_errors: got ferr=%0d ovr=%0d expected 0/0", n_ferr, n_ovr);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] g;
        int gap;
        clear_obs();
        for (int k = 0; k < 16; k++) begin
            b   = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 2));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            if (gap > 0) #(gap * FAST_BIT_NS);
        end
        cycles(2);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_checks++;
            if (g !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %02h expected %02h", i, g, exp_q[i]); end
        end
        n_checks++;
        if (n_ferr !== 0 || n_ovr !== 0 || n_perr !== 0) begin
            n_fail++; $display("FAIL rand_errors: got ferr=%0d ovr=%0d perr=%0d expected 0/0/0", n_ferr, n_ovr, n_perr);
        end
    endtask

    initial begin
        fast_if.rx_ready = 1'b1;
        def_if.rx_ready  = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
